pool_arbiter: RTL
=================

POOL_ARBITER -- requirements
Module: pool_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning the number of requesting cores sharing one pool engine.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of RUN cycles allowed before the job is aborted.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset: synchronous, active-high.
REQ-005 SHALL have port req  input  N_REQ  per-core pooling request, level-held until the matching req_done pulse.
REQ-006 SHALL have port gnt  output  N_REQ  one-hot grant, all-zero when idle.
REQ-007 SHALL have port eng_sel  output  clog2(N_REQ)  index of the granted core, driving the engine input-feature-map mux.
REQ-008 SHALL have port eng_start  output  1  single-cycle start pulse to the pool engine.
REQ-009 SHALL have port eng_done  input  1  engine completion, level or pulse.
REQ-010 SHALL have port req_done  output  N_REQ  one-cycle completion pulse to the granted core.
REQ-011 SHALL have port busy  output  1  high when state is not IDLE.
REQ-012 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, START, RUN and DONE, with every output registered.
REQ-014 IDLE: when any req bit is high, SHALL select by round-robin starting at index ptr, load gnt/eng_sel, and go to START; with no request, SHALL remain in IDLE.
REQ-015 START: SHALL drive eng_start=1 for exactly one cycle, clear the run counter, and go to RUN.
REQ-016 RUN: SHALL hold gnt/eng_sel stable and increment the counter each cycle; eng_done=1 SHALL cause a move to DONE.
REQ-017 RUN: when the counter equals TIMEOUT-1 and eng_done=0, SHALL set err=1 and go to DONE.
REQ-018 RUN: when eng_done and the timeout occur in the same cycle, eng_done SHALL win and err SHALL be left unchanged.
REQ-019 DONE: SHALL pulse req_done[eng_sel] for one cycle, clear gnt to 0, set ptr = (eng_sel+1) mod N_REQ, and go to IDLE.
REQ-020 Latency: with req first seen in IDLE at cycle t, gnt and eng_start SHALL be high at t+1; with eng_done seen at cycle d, req_done SHALL be high at d+1 and the earliest next grant SHALL be at d+3.
REQ-021 eng_done SHALL be ignored outside RUN.
REQ-022 Deasserting req while granted SHALL NOT abort the job; the job SHALL complete normally.
REQ-023 New req bits arriving during START, RUN or DONE SHALL be arbitrated only on return to IDLE.
REQ-024 Round-robin fairness: a continuously asserted request SHALL be granted within N_REQ jobs.
REQ-025 The run counter SHALL be clog2(TIMEOUT+1) bits wide and SHALL saturate, never wrap.
REQ-026 err SHALL be cleared only by rst.

Reset
REQ-027 While rst=1: state=IDLE, gnt=0, eng_sel=0, eng_start=0, req_done=0, busy=0, err=0, ptr=0, counter=0.
REQ-028 Reset asserted mid-job SHALL abandon the job, emit no req_done, and return all outputs to reset values on the next clock.

Verification
REQ-029 req=0001 at cycle 0 and eng_done at cycle 5 -> gnt=0001 and eng_start=1 at cycle 1, req_done=0001 at cycle 6, busy=0 at cycle 7.
REQ-030 req=1111 held, with the engine completing each job in 3 cycles -> grant order 0,1,2,3,0 and err=0.
REQ-031 After a job for core 2 completes, req=1011 -> core 3 is granted next, then core 0.
REQ-032 req=0100 and eng_done never asserted -> err=1 and req_done=0100 after 255 RUN cycles, and err stays 1 afterwards.
REQ-033 rst pulsed during RUN of core 1 -> no req_done pulse, gnt=0 and busy=0 the cycle after rst, and ptr=0 so that core 0 wins a following req=0011.
REQ-034 eng_done held high in IDLE and START -> no effect, and the job completes only on an eng_done seen in RUN.

Source files
------------

// File: rtl/pool_arbiter.sv
// Round-robin arbiter sharing one pooling engine among N_REQ cores.
// Sequences each job through START/RUN/DONE with a saturating run-cycle watchdog.
module pool_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 255,
    localparam int SEL_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] eng_sel,
    output logic             eng_start,
    input  logic             eng_done,
    output logic [N_REQ-1:0] req_done,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [SEL_W-1:0]   ptr, ptr_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [N_REQ-1:0]   gnt_nx, req_done_nx;
    logic [SEL_W-1:0]   eng_sel_nx;
    logic               eng_start_nx, busy_nx, err_nx;
    logic               pick_found;
    logic [SEL_W-1:0]   pick_idx;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
        logic [N_REQ-1:0] o;
        o    = '0;
        o[s] = 1'b1;
        return o;
    endfunction

    // First requester at or after ptr, wrapping around.
    always_comb begin
        int j;
        pick_found = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!pick_found && req[j]) begin
                pick_found = 1'b1;
                pick_idx   = SEL_W'(j);
            end
        end
    end

    always_comb begin
        state_nx     = state;
        ptr_nx       = ptr;
        cnt_nx       = cnt;
        gnt_nx       = gnt;
        eng_sel_nx   = eng_sel;
        eng_start_nx = 1'b0;
        req_done_nx  = '0;
        err_nx       = err;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_nx       = onehot(pick_idx);
                    eng_sel_nx   = pick_idx;
                    eng_start_nx = 1'b1;
                    state_nx     = START;
                end
            end
            START: begin
                cnt_nx   = '0;
                state_nx = RUN;
            end
            RUN: begin
                if (cnt != '1) cnt_nx = cnt + 1'b1;
                // A completion in the timeout cycle still counts as success.
                if (eng_done) begin
                    req_done_nx = onehot(eng_sel);
                    state_nx    = DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nx      = 1'b1;
                    req_done_nx = onehot(eng_sel);
                    state_nx    = DONE;
                end
            end
            DONE: begin
                gnt_nx   = '0;
                ptr_nx   = (eng_sel == SEL_W'(N_REQ - 1)) ? '0 : eng_sel + 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            eng_sel   <= '0;
            eng_start <= 1'b0;
            req_done  <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            cnt       <= cnt_nx;
            gnt       <= gnt_nx;
            eng_sel   <= eng_sel_nx;
            eng_start <= eng_start_nx;
            req_done  <= req_done_nx;
            busy      <= busy_nx;
            err       <= err_nx;
        end
    end

endmodule
